// File: rtl/fxp_div_flow_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : fxp_div_flow_ctrl_if
// Brief    : Handshake and result bus between divider flow control and its env.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fxp_div_flow_ctrl_if #(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int DEPTH = 4
);
  logic                       s_valid;
  logic                       s_ready;
  logic                       issue;
  logic [WOI+WOF-1:0]         div_out;
  logic                       div_overflow;
  logic                       m_valid;
  logic                       m_ready;
  logic [WOI+WOF-1:0]         m_data;
  logic                       m_overflow;
  logic [$clog2(DEPTH):0]     outstanding;

  modport master (
    output s_valid, div_out, div_overflow, m_ready,
    input  s_ready, issue, m_valid, m_data, m_overflow, outstanding
  );

  modport slave (
    input  s_valid, div_out, div_overflow, m_ready,
    output s_ready, issue, m_valid, m_data, m_overflow, outstanding
  );
endinterface

`default_nettype wire

// File: rtl/fxp_div_flow_ctrl.sv
//------------------------------------------------------------------------------
// Module   : fxp_div_flow_ctrl
// Brief    : Credit-gated issue control and in-order result FIFO for a
//            fixed-latency pipelined fixed-point divider.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fxp_div_flow_ctrl #(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int LAT   = WOI + WOF + 3,
  parameter int DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fxp_div_flow_ctrl_if.slave bus
);
  localparam int c_w  = WOI + WOF;
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [LAT-1:0]  vsr_q, vsr_d;
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0] count_q, count_d;
  logic [c_cw-1:0] outst_q, outst_d;
  logic [c_w:0]    mem_q [DEPTH];

  logic w_sready, w_issue, w_cap, w_mvalid, w_pop;
  logic [c_w:0] w_head;

  // Credits count every pair between issue and pop, so the FIFO can never overflow.
  assign w_sready = (outst_q < c_depth);
  assign w_issue  = bus.s_valid & w_sready;
  assign w_cap    = vsr_q[LAT-1];
  assign w_mvalid = (count_q != '0);
  assign w_pop    = w_mvalid & bus.m_ready;
  assign w_head   = mem_q[rd_ptr_q];

  generate
    if (LAT == 1) begin : g_lat1
      assign vsr_d = w_issue;
    end else begin : g_latn
      assign vsr_d = {vsr_q[LAT-2:0], w_issue};
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    outst_d  = outst_q;
    if (w_cap) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (w_pop) rd_ptr_d = rd_ptr_q + c_ptr_one;
    case ({w_cap, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
    case ({w_issue, w_pop})
      2'b10:   outst_d = outst_q + c_cnt_one;
      2'b01:   outst_d = outst_q - c_cnt_one;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      outst_q  <= '0;
    end else begin
      vsr_q    <= vsr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
    end
  end

  // Storage is left unreset; the output mux masks it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_cap) mem_q[wr_ptr_q] <= {bus.div_overflow, bus.div_out};
  end

  assign bus.s_ready     = w_sready;
  assign bus.issue       = w_issue;
  assign bus.m_valid     = w_mvalid;
  assign bus.m_data      = w_mvalid ? w_head[c_w-1:0] : '0;
  assign bus.m_overflow  = w_mvalid & w_head[c_w];
  assign bus.outstanding = outst_q;

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_cap && (count_q == c_depth)));

endmodule

`default_nettype wire

// File: tb/tb_fxp_div_flow_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_fxp_div_flow_ctrl
// Brief    : Randomized self-checking bench with a fixed-latency divider model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fxp_div_flow_ctrl;
  localparam int WOI   = 8;
  localparam int WOF   = 8;
  localparam int LAT   = WOI + WOF + 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
    int          e;
  } op_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   edge_n;
  int   n_iss;
  int   n_pop;
  op_t  exp_q[$];
  logic [16:0] res_at [int];

  fxp_div_flow_ctrl_if #(.WOI(WOI), .WOF(WOF), .DEPTH(DEPTH)) bus ();

  fxp_div_flow_ctrl #(.WOI(WOI), .WOF(WOF), .LAT(LAT), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // Q8.8 division with saturation to the largest positive quotient.
  function automatic logic [16:0] fdiv(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] q;
    if (b == 16'h0) return {1'b1, 16'h7FFF};
    q = ({16'h0, a} << WOF) / {16'h0, b};
    if (q > 32'h7FFF) return {1'b1, 16'h7FFF};
    return {1'b0, q[15:0]};
  endfunction

  function automatic logic head_ready();
    if (exp_q.size() == 0) return 1'b0;
    return (exp_q[0].e + LAT <= edge_n);
  endfunction

  task automatic check_outputs();
    logic mv;
    mv = head_ready();
    chk("s_ready", {31'h0, bus.s_ready}, {31'h0, exp_q.size() < DEPTH});
    chk("outstanding", 32'(bus.outstanding), 32'(exp_q.size()));
    chk("m_valid", {31'h0, bus.m_valid}, {31'h0, mv});
    if (mv) begin
      chk("m_data", 32'(bus.m_data), 32'(exp_q[0].q));
      chk("m_overflow", {31'h0, bus.m_overflow}, {31'h0, exp_q[0].ovf});
    end else begin
      chk("m_data_idle", 32'(bus.m_data), 32'h0);
      chk("m_overflow_idle", {31'h0, bus.m_overflow}, 32'h0);
    end
  endtask

  // One clock: drive at the falling edge, check after the next falling edge.
  task automatic cycle(input logic sv, input logic mr, input logic [15:0] a, input logic [15:0] b);
    logic issue_now;
    logic pop_now;
    logic [16:0] r;
    bus.s_valid = sv;
    bus.m_ready = mr;
    if (res_at.exists(edge_n + 1)) begin
      {bus.div_overflow, bus.div_out} = res_at[edge_n + 1];
      res_at.delete(edge_n + 1);
    end else begin
      bus.div_out      = 16'($urandom);
      bus.div_overflow = 1'($urandom);
    end
    #1;
    issue_now = sv && (exp_q.size() < DEPTH);
    pop_now   = head_ready() && mr;
    chk("issue", {31'h0, bus.issue}, {31'h0, issue_now});
    if (bus.issue) n_iss++;
    if (bus.m_valid && bus.m_ready) n_pop++;
    @(posedge clk);
    edge_n++;
    if (issue_now) begin
      r = fdiv(a, b);
      exp_q.push_back('{q: r[15:0], ovf: r[16], e: edge_n});
      res_at[edge_n + LAT] = r;
    end
    if (pop_now) void'(exp_q.pop_front());
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(1'b0, mr, 16'h0, 16'h0);
  endtask

  task automatic rand_op(input logic sv, input logic mr);
    cycle(sv, mr, 16'($urandom_range(0, 16'h7FFF)), 16'($urandom_range(1, 16'h7FFF)));
  endtask

  initial begin
    int ops;
    int guard;
    int pops_before;
    n_cmp  = 0;
    n_err  = 0;
    edge_n = 0;
    n_iss  = 0;
    n_pop  = 0;
    rst    = 1'b1;
    bus.s_valid      = 1'b0;
    bus.m_ready      = 1'b0;
    bus.div_out      = 16'h0;
    bus.div_overflow = 1'b0;

    @(negedge clk);
    check_outputs();
    chk("reset_issue", {31'h0, bus.issue}, 32'h0);
    idle(2, 1'b0);
    rst = 1'b0;
    idle(2, 1'b0);

    // single op with the result held, then popped
    cycle(1'b1, 1'b0, 16'h0400, 16'h0200);
    idle(LAT + 5, 1'b0);
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    idle(3, 1'b0);

    // burst with downstream stalled
    n_iss = 0;
    for (int i = 0; i < 30; i++) rand_op(1'b1, 1'b0);
    chk("burst_issues", 32'(n_iss), 32'd4);

    // single-cycle credit return
    n_iss = 0;
    pops_before = n_pop;
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    chk("credit_pop", 32'(n_pop - pops_before), 32'd1);
    for (int i = 0; i < 6; i++) rand_op(1'b1, 1'b0);
    chk("credit_issues", 32'(n_iss), 32'd1);
    idle(LAT + 10, 1'b1);

    // overflow on the middle entry only
    cycle(1'b1, 1'b1, 16'h0400, 16'h0100);
    cycle(1'b1, 1'b1, 16'h7F00, 16'h0080);
    cycle(1'b1, 1'b1, 16'h0100, 16'h0400);
    idle(LAT + 5, 1'b1);

    // reset with three ops in flight; their late divider outputs must be ignored
    for (int i = 0; i < 3; i++) rand_op(1'b1, 1'b1);
    idle(7, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_outputs();
    idle(2, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'($urandom), 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 16'h1800, 16'h0300);
    idle(LAT + 2, 1'b0);
    idle(3, 1'b1);

    // random traffic against the reference queue
    n_iss = 0;
    n_pop = 0;
    ops   = 0;
    guard = 0;
    while (ops < 1000 && guard < 20000) begin
      rand_op($urandom_range(0, 3) != 0, 1'($urandom));
      ops = n_iss;
      guard++;
    end
    chk("random_ops", 32'(ops), 32'd1000);
    idle(LAT + 2 * DEPTH + 5, 1'b1);
    chk("random_no_loss", 32'(n_pop), 32'(n_iss));
    chk("final_outstanding", 32'(bus.outstanding), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
